// File: rtl/four_bit_alu.sv
// ---------------------------------------------------------------------------
// four_bit_alu
//   4-bit, 8-function ALU with a registered result and flag. Operands are
//   sampled on every rising edge and the result appears one cycle later.
//   There is no handshake, so a new operation may be issued every cycle.
//
//   Ports
//     clk       in   1  single clock, rising edge
//     rst       in   1  synchronous, active-high reset (clears R and overFlow)
//     A         in   4  operand A
//     B         in   4  operand B
//     C         in   1  carry-in / borrow-in / shift fill bit
//     Mode      in   3  operation select
//     R         out  4  registered result
//     overFlow  out  1  registered flag (carry, borrow, shifted-out bit or 0)
//
//   Mode | operation | overFlow
//   000  | A + B + C | carry-out
//   001  | A - B - C | borrow-out
//   010  | A & B     | 0
//   011  | A | B     | 0
//   100  | A ^ B     | 0
//   101  | {A[2:0],C}| A[3]
//   110  | {C,A[3:1]}| A[0]
//   111  | ~(A ^ B)  | 0
//
//   Build option
//     SIGNED_OVF_EN : when defined, ADD and SUB report two's-complement
//                     signed overflow instead of unsigned carry/borrow.
//                     R and all other modes are unchanged.
// ---------------------------------------------------------------------------
module four_bit_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C,
  input  logic [2:0] Mode,
  output logic [3:0] R,
  output logic       overFlow
);

  localparam logic [2:0] MODE_ADD  = 3'b000;
  localparam logic [2:0] MODE_SUB  = 3'b001;
  localparam logic [2:0] MODE_AND  = 3'b010;
  localparam logic [2:0] MODE_OR   = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_SHL  = 3'b101;
  localparam logic [2:0] MODE_SHR  = 3'b110;
  localparam logic [2:0] MODE_XNOR = 3'b111;

  logic [4:0] sum;
  logic [4:0] diff;
  logic       add_ovf;
  logic       sub_ovf;
  logic [3:0] r_d, r_q;
  logic       ovf_d, ovf_q;

  // Zero-extended to 5 bits so bit 4 is the carry (ADD) or the borrow (SUB):
  // a negative difference wraps with bit 4 set.
  assign sum  = {1'b0, A} + {1'b0, B} + {4'b0000, C};
  assign diff = {1'b0, A} - {1'b0, B} - {4'b0000, C};

`ifdef SIGNED_OVF_EN
  // Overflow when the operands imply a sign the 4-bit result cannot hold.
  assign add_ovf = (A[3] == B[3]) && (sum[3]  != A[3]);
  assign sub_ovf = (A[3] != B[3]) && (diff[3] != A[3]);
`else
  assign add_ovf = sum[4];
  assign sub_ovf = diff[4];
`endif

  always_comb begin
    r_d   = 4'b0000;
    ovf_d = 1'b0;
    case (Mode)
      MODE_ADD: begin
        r_d   = sum[3:0];
        ovf_d = add_ovf;
      end
      MODE_SUB: begin
        r_d   = diff[3:0];
        ovf_d = sub_ovf;
      end
      MODE_AND:  r_d = A & B;
      MODE_OR:   r_d = A | B;
      MODE_XOR:  r_d = A ^ B;
      MODE_SHL: begin
        r_d   = {A[2:0], C};
        ovf_d = A[3];
      end
      MODE_SHR: begin
        r_d   = {C, A[3:1]};
        ovf_d = A[0];
      end
      MODE_XNOR: r_d = ~(A ^ B);
      // Reached only for unknown Mode values; outputs go to zero.
      default: begin
        r_d   = 4'b0000;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= 4'b0000;
      ovf_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      ovf_q <= ovf_d;
    end
  end

  assign R        = r_q;
  assign overFlow = ovf_q;

endmodule

// File: tb/tb_four_bit_alu.sv
// ---------------------------------------------------------------------------
// tb_four_bit_alu
//   Drives directed and random operations into four_bit_alu. Each issued
//   operation pushes its expected result, computed with integer arithmetic,
//   into a queue; a monitor pops one entry after every rising edge and
//   compares it with R/overFlow.
// ---------------------------------------------------------------------------
module tb_four_bit_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       C;
  logic [2:0] Mode;
  logic [3:0] R;
  logic       overFlow;

  typedef struct {
    logic [3:0] r;
    logic       ovf;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  four_bit_alu dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .C        (C),
    .Mode     (Mode),
    .R        (R),
    .overFlow (overFlow)
  );

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic r_in, input logic [3:0] a,
                                 input logic [3:0] b, input logic c,
                                 input logic [2:0] m, input int id);
    exp_t e;
    int ua, ub, uc, sa, sb, s;
    ua = int'(a); ub = int'(b); uc = int'(c);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    e.id  = id;
    e.r   = 4'd0;
    e.ovf = 1'b0;
    if (!r_in) begin
      case (m)
        3'd0: begin
          s = ua + ub + uc;
          e.r = 4'(s % 16);
`ifdef SIGNED_OVF_EN
          e.ovf = ((sa + sb + uc) > 7) || ((sa + sb + uc) < -8);
`else
          e.ovf = (s > 15);
`endif
        end
        3'd1: begin
          s = ua - ub - uc;
          e.r = 4'((s + 32) % 16);
`ifdef SIGNED_OVF_EN
          e.ovf = ((sa - sb - uc) > 7) || ((sa - sb - uc) < -8);
`else
          e.ovf = (s < 0);
`endif
        end
        3'd2: e.r = 4'(ua & ub);
        3'd3: e.r = 4'(ua | ub);
        3'd4: e.r = 4'(ua ^ ub);
        3'd5: begin
          e.r   = 4'(((ua * 2) % 16) + uc);
          e.ovf = (ua >= 8);
        end
        3'd6: begin
          e.r   = 4'((ua / 2) + uc * 8);
          e.ovf = (ua % 2) == 1;
        end
        default: e.r = 4'(15 - (ua ^ ub));
      endcase
    end
    return e;
  endfunction

  task automatic issue(input logic r_in, input logic [3:0] a,
                       input logic [3:0] b, input logic c,
                       input logic [2:0] m, input int id);
    @(negedge clk);
    rst = r_in; A = a; B = b; C = c; Mode = m;
    exp_q.push_back(model(r_in, a, b, c, m, id));
  endtask

  // Monitor: the DUT presents a new result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (R !== e.r || overFlow !== e.ovf) begin
          n_bad++;
          $display("FAIL op%0d: got R=%b ovf=%b, expected R=%b ovf=%b",
                   e.id, R, overFlow, e.r, e.ovf);
        end
      end
    end
  end

  // Directed constants from the specified examples: checked directly too.
  task automatic check_const(input logic [3:0] er, input logic eo, input string nm);
    @(posedge clk);
    #3;
    n_cmp++;
    if (R !== er || overFlow !== eo) begin
      n_bad++;
      $display("FAIL %s: got R=%b ovf=%b, expected R=%b ovf=%b", nm, R, overFlow, er, eo);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    int id = 0;
    rst = 1'b1; A = 4'd0; B = 4'd0; C = 1'b0; Mode = 3'd0;

    // Reset with arbitrary inputs, then held.
    issue(1'b1, 4'hF, 4'hF, 1'b1, 3'd0, id++);
    check_const(4'b0000, 1'b0, "reset");
    issue(1'b1, 4'h9, 4'h3, 1'b1, 3'd6, id++);
    check_const(4'b0000, 1'b0, "reset_hold");

    // Spec examples (also checked by the scoreboard).
    issue(1'b0, 4'b0101, 4'b1010, 1'b1, 3'd0, id++);
`ifdef SIGNED_OVF_EN
    check_const(4'b0000, 1'b0, "add_0101_1010_1");
`else
    check_const(4'b0000, 1'b1, "add_0101_1010_1");
`endif
    issue(1'b0, 4'b1010, 4'b0101, 1'b0, 3'd0, id++);
    check_const(4'b1111, 1'b0, "add_1010_0101_0");
    issue(1'b0, 4'b1111, 4'b1111, 1'b1, 3'd0, id++);
`ifdef SIGNED_OVF_EN
    check_const(4'b1111, 1'b0, "add_max");
`else
    check_const(4'b1111, 1'b1, "add_max");
`endif
    issue(1'b0, 4'b0101, 4'b0011, 1'b0, 3'd0, id++);
`ifdef SIGNED_OVF_EN
    check_const(4'b1000, 1'b1, "add_signed_ovf");
`else
    check_const(4'b1000, 1'b0, "add_signed_ovf");
`endif
`ifndef SIGNED_OVF_EN
    issue(1'b0, 4'b0011, 4'b1100, 1'b0, 3'd1, id++);
    check_const(4'b0111, 1'b1, "sub_0011_1100");
    issue(1'b0, 4'b1100, 4'b1100, 1'b1, 3'd1, id++);
    check_const(4'b1111, 1'b1, "sub_eq_borrow");
    issue(1'b0, 4'b0000, 4'b0000, 1'b1, 3'd1, id++);
    check_const(4'b1111, 1'b1, "sub_min");
`endif
    issue(1'b0, 4'b1100, 4'b0011, 1'b0, 3'd1, id++);
    check_const(4'b1001, 1'b0, "sub_1100_0011");
    issue(1'b0, 4'b1100, 4'b1010, 1'b1, 3'd2, id++);
    check_const(4'b1000, 1'b0, "and");
    issue(1'b0, 4'b1100, 4'b1010, 1'b1, 3'd3, id++);
    check_const(4'b1110, 1'b0, "or");
    issue(1'b0, 4'b1100, 4'b1010, 1'b1, 3'd4, id++);
    check_const(4'b0110, 1'b0, "xor");
    issue(1'b0, 4'b1100, 4'b1010, 1'b1, 3'd7, id++);
    check_const(4'b1001, 1'b0, "xnor");
    issue(1'b0, 4'b1000, 4'b0000, 1'b0, 3'd5, id++);
    check_const(4'b0000, 1'b1, "shl");
    issue(1'b0, 4'b0101, 4'b0000, 1'b1, 3'd6, id++);
    check_const(4'b1010, 1'b1, "shr");

    // Back-to-back random operations with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      issue((rnd[31:27] == 5'd0), rnd[3:0], rnd[7:4], rnd[8], rnd[11:9], id++);
    end
    issue(1'b0, 4'hF, 4'h1, 1'b0, 3'd0, id++);
    issue(1'b1, 4'hF, 4'h1, 1'b0, 3'd0, id++);
    issue(1'b0, 4'h7, 4'h2, 1'b1, 3'd1, id++);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
    end
  end

endmodule
